// File: rtl/color_pkg.sv
// Shared scene constants and race sequencer state type for the grass band.
package color_pkg;

    // Vertical placement of the grass band, shared with the renderer
    localparam int GRASS_Y_TOP = 140;
    localparam int GRASS_H     = 10;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } race_state_t;

endpackage

// File: rtl/frame_cmd_latch.sv
// Holds race commands from game logic until the next frame boundary consumes them.
// Commands arriving in the same cycle as frame_start are folded into that update.
module frame_cmd_latch #(
    parameter int SPEED_W   = 4,
    parameter int MAX_SPEED = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               speed_we,
    input  logic [SPEED_W-1:0] speed_req,
    output logic               start_eff,
    output logic               stop_eff,
    output logic [SPEED_W-1:0] target_eff
);

    localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_SPEED);

    logic               pend_start;
    logic               pend_stop;
    logic [SPEED_W-1:0] target;
    logic [SPEED_W-1:0] req_clamp;

    assign req_clamp  = (speed_req > MAX_S) ? MAX_S : speed_req;
    assign start_eff  = pend_start | cmd_start;
    assign stop_eff   = pend_stop  | cmd_stop;
    assign target_eff = speed_we ? req_clamp : target;

    // Sticky pending flags cleared at frame_start; target keeps the last strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_start <= 1'b0;
            pend_stop  <= 1'b0;
            target     <= '0;
        end else begin
            if (frame_start) begin
                pend_start <= 1'b0;
                pend_stop  <= 1'b0;
            end else begin
                pend_start <= pend_start | cmd_start;
                pend_stop  <= pend_stop  | cmd_stop;
            end
            if (speed_we)
                target <= req_clamp;
        end
    end

endmodule

// File: rtl/grass_scroll_ctrl.sv
// Per-frame race sequencer for the grass band: speed ramp, wrapped scroll offset,
// saturating distance and finish flash. Every output changes only on the cycle
// after frame_start, so the renderer always sees frame-stable values.
module grass_scroll_ctrl
    import color_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int SPEED_W      = 4,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_STEP   = 1,
    parameter int FINISH_DIST  = 4800,
    parameter int FLASH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               speed_we,
    input  logic [SPEED_W-1:0] speed_req,
    output logic [9:0]         scroll_x,
    output logic [SPEED_W-1:0] cur_speed,
    output logic [15:0]        distance,
    output logic               highlight,
    output logic               race_active,
    output logic               race_done
);

    localparam int FL_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [SPEED_W-1:0] STEP    = SPEED_W'(ACCEL_STEP);
    localparam logic [10:0]        HRES_11 = 11'(H_RES);
    localparam logic [15:0]        FIN_16  = 16'(FINISH_DIST);
    localparam logic [FL_W-1:0]    FL_LAST = FL_W'(FLASH_FRAMES - 1);

    race_state_t        state, state_n;
    logic [SPEED_W-1:0] speed_n;
    logic [9:0]         scroll_n;
    logic [15:0]        dist_n;
    logic               hl_n, done_n;
    logic [FL_W-1:0]    flash_cnt, flash_n;

    logic               start_eff, stop_eff;
    logic [SPEED_W-1:0] target;

    logic [SPEED_W:0]   up_sum;
    logic [SPEED_W-1:0] ramp;
    race_state_t        ramp_state;
    logic [10:0]        scroll_sum;
    logic [9:0]         scroll_wrap;
    logic [16:0]        dist_sum;
    logic [15:0]        dist_sat;

    frame_cmd_latch #(
        .SPEED_W   (SPEED_W),
        .MAX_SPEED (MAX_SPEED)
    ) u_cmd (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .speed_we    (speed_we),
        .speed_req   (speed_req),
        .start_eff   (start_eff),
        .stop_eff    (stop_eff),
        .target_eff  (target)
    );

    assign race_active = (state == ACCEL) || (state == CRUISE) || (state == DECEL);

    // Speed ramp one step toward target, plus wrapped scroll and saturated distance
    always_comb begin
        up_sum = {1'b0, cur_speed} + {1'b0, STEP};
        ramp   = cur_speed;
        if (target > cur_speed)
            ramp = (up_sum >= {1'b0, target}) ? target : up_sum[SPEED_W-1:0];
        else if (target < cur_speed)
            ramp = ((cur_speed - target) <= STEP) ? target : (cur_speed - STEP);

        ramp_state = CRUISE;
        if (ramp < target)
            ramp_state = ACCEL;
        else if (ramp > target)
            ramp_state = DECEL;

        scroll_sum  = {1'b0, scroll_x} + 11'(ramp);
        scroll_wrap = (scroll_sum >= HRES_11) ? 10'(scroll_sum - HRES_11) : scroll_sum[9:0];

        dist_sum = {1'b0, distance} + 17'(ramp);
        dist_sat = (dist_sum >= {1'b0, FIN_16}) ? FIN_16 : dist_sum[15:0];
    end

    // Frame-boundary FSM: stop beats start, finishing beats a plain ramp step
    always_comb begin
        state_n  = state;
        speed_n  = cur_speed;
        scroll_n = scroll_x;
        dist_n   = distance;
        hl_n     = highlight;
        flash_n  = flash_cnt;
        done_n   = 1'b0;
        if (frame_start) begin
            case (state)
                IDLE: begin
                    if (start_eff && !stop_eff) begin
                        state_n = ACCEL;
                        speed_n = '0;
                        dist_n  = '0;
                    end
                end
                ACCEL, CRUISE, DECEL: begin
                    if (stop_eff) begin
                        state_n = IDLE;
                        speed_n = '0;
                    end else begin
                        scroll_n = scroll_wrap;
                        dist_n   = dist_sat;
                        if (dist_sat == FIN_16) begin
                            state_n = DONE;
                            speed_n = '0;
                            done_n  = 1'b1;
                            hl_n    = 1'b0;
                            flash_n = '0;
                        end else begin
                            state_n = ramp_state;
                            speed_n = ramp;
                        end
                    end
                end
                DONE: begin
                    if (stop_eff) begin
                        state_n = IDLE;
                        hl_n    = 1'b0;
                        flash_n = '0;
                    end else if (start_eff) begin
                        state_n = ACCEL;
                        dist_n  = '0;
                        hl_n    = 1'b0;
                        flash_n = '0;
                    end else if (flash_cnt == FL_LAST) begin
                        flash_n = '0;
                        hl_n    = ~highlight;
                    end else begin
                        flash_n = flash_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_speed <= '0;
            scroll_x  <= '0;
            distance  <= '0;
            highlight <= 1'b0;
            flash_cnt <= '0;
            race_done <= 1'b0;
        end else begin
            state     <= state_n;
            cur_speed <= speed_n;
            scroll_x  <= scroll_n;
            distance  <= dist_n;
            highlight <= hl_n;
            flash_cnt <= flash_n;
            race_done <= done_n;
        end
    end

endmodule

// File: tb/tb_grass_scroll_ctrl.sv
// Directed bench for grass_scroll_ctrl: a vector table for the opening race
// sequence, then hand-written sequences for wrap, stop, finish/flash, clamp and reset.
module tb_grass_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start, cmd_start, cmd_stop, speed_we;
    logic [3:0]  speed_req;
    logic [9:0]  scroll_x;
    logic [3:0]  cur_speed;
    logic [15:0] distance;
    logic        highlight, race_active, race_done;

    int checks   = 0;
    int failures = 0;

    grass_scroll_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .speed_we    (speed_we),
        .speed_req   (speed_req),
        .scroll_x    (scroll_x),
        .cur_speed   (cur_speed),
        .distance    (distance),
        .highlight   (highlight),
        .race_active (race_active),
        .race_done   (race_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cs, cp, we;
        logic [3:0] req;
        logic       fr;
        int         e_scroll, e_speed, e_dist, e_act, e_hl;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int sx, input int sp, input int d,
                            input int act, input int hl);
        chk({tag, ".scroll_x"},    32'(scroll_x),    32'(sx));
        chk({tag, ".cur_speed"},   32'(cur_speed),   32'(sp));
        chk({tag, ".distance"},    32'(distance),    32'(d));
        chk({tag, ".race_active"}, 32'(race_active), 32'(act));
        chk({tag, ".highlight"},   32'(highlight),   32'(hl));
    endtask

    // Two idle cycles, then one cycle with the given strobes; outputs checked after
    task automatic step(input logic cs, input logic cp, input logic we,
                        input logic [3:0] req, input logic fr);
        repeat (2) @(negedge clk);
        cmd_start   = cs;
        cmd_stop    = cp;
        speed_we    = we;
        speed_req   = req;
        frame_start = fr;
        @(negedge clk);
        cmd_start   = 1'b0;
        cmd_stop    = 1'b0;
        speed_we    = 1'b0;
        speed_req   = '0;
        frame_start = 1'b0;
    endtask

    task automatic frame();
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 4'd0, 1,   0, 0,  0, 0, 0};
        vecs[1]  = '{0, 0, 0, 4'd0, 1,   0, 0,  0, 0, 0};
        vecs[2]  = '{0, 0, 0, 4'd0, 1,   0, 0,  0, 0, 0};
        vecs[3]  = '{1, 0, 1, 4'd4, 1,   0, 0,  0, 1, 0};
        vecs[4]  = '{0, 0, 0, 4'd0, 1,   1, 1,  1, 1, 0};
        vecs[5]  = '{0, 0, 0, 4'd0, 1,   3, 2,  3, 1, 0};
        vecs[6]  = '{0, 0, 0, 4'd0, 1,   6, 3,  6, 1, 0};
        vecs[7]  = '{0, 0, 0, 4'd0, 1,  10, 4, 10, 1, 0};
        vecs[8]  = '{0, 0, 0, 4'd0, 1,  14, 4, 14, 1, 0};
        vecs[9]  = '{0, 0, 0, 4'd0, 1,  18, 4, 18, 1, 0};
        vecs[10] = '{0, 0, 1, 4'd2, 0,  18, 4, 18, 1, 0};
        vecs[11] = '{0, 0, 1, 4'd4, 0,  18, 4, 18, 1, 0};
        vecs[12] = '{0, 0, 0, 4'd0, 1,  22, 4, 22, 1, 0};

        reset = 1'b1; frame_start = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        speed_we = 1'b0; speed_req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_outs("reset", 0, 0, 0, 0, 0);
        chk("reset.race_done", 32'(race_done), 32'd0);

        // Idle frames, race start with coincident speed strobe, ramp, last-strobe-wins
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].cs, vecs[i].cp, vecs[i].we, vecs[i].req, vecs[i].fr);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_scroll, vecs[i].e_speed,
                     vecs[i].e_dist, vecs[i].e_act, vecs[i].e_hl);
        end

        // Cruise at 4 up to scroll 638, then wrap
        for (int i = 0; i < 154; i++) frame();
        chk_outs("pre_wrap", 638, 4, 638, 1, 0);
        frame();
        chk_outs("wrap", 2, 4, 642, 1, 0);

        // Start and stop pending in the same frame while cruising: stop wins
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        frame();
        chk_outs("stop_wins", 2, 0, 642, 0, 0);

        // New race to the finish line
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk_outs("restart", 2, 0, 0, 1, 0);
        for (int i = 0; i < 1201; i++) frame();
        chk_outs("pre_finish", 320, 4, 4798, 1, 0);
        frame();
        chk("finish.distance",    32'(distance),    32'd4800);
        chk("finish.race_active", 32'(race_active), 32'd0);
        chk("finish.cur_speed",   32'(cur_speed),   32'd0);
        chk("finish.race_done",   32'(race_done),   32'd1);
        @(negedge clk);
        chk("finish.done_pulse_end", 32'(race_done), 32'd0);
        for (int i = 0; i < 7; i++) frame();
        chk("flash7.highlight", 32'(highlight), 32'd0);
        frame();
        chk("flash8.highlight", 32'(highlight), 32'd1);
        chk("flash8.distance",  32'(distance),  32'd4800);
        for (int i = 0; i < 7; i++) frame();
        chk("flash15.highlight", 32'(highlight), 32'd1);
        frame();
        chk("flash16.highlight", 32'(highlight), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        frame();
        chk("rerace.race_active", 32'(race_active), 32'd1);
        chk("rerace.distance",    32'(distance),    32'd0);
        chk("rerace.highlight",   32'(highlight),   32'd0);

        // Speed request above the limit clamps to 8
        step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
        for (int i = 0; i < 8; i++) frame();
        chk("clamp.ramp_top", 32'(cur_speed), 32'd8);
        frame();
        chk("clamp.held", 32'(cur_speed), 32'd8);

        // Reset in the middle of an acceleration with a start command pending
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("stop_idle.race_active", 32'(race_active), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) frame();
        chk("mid_accel.cur_speed",   32'(cur_speed),   32'd3);
        chk("mid_accel.race_active", 32'(race_active), 32'd1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_outs("mid_reset", 0, 0, 0, 0, 0);
        chk("mid_reset.race_done", 32'(race_done), 32'd0);
        frame();
        chk("pend_lost.race_active", 32'(race_active), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        frame();
        chk("target_reset.cur_speed",   32'(cur_speed),   32'd0);
        chk("target_reset.race_active", 32'(race_active), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
